// File: rtl/usb_bit_unstuff.sv
// USB 2.0 receive-path bit unstuffer: strips stuffed zeros, flags them with halt_rx_shift,
// and tags every registered output bit with a one-hot packet-field qualifier.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | idle / hunting for sync (0000_0001) in the unstuffed stream
//   S_PID   | collecting 8 PID bits, LSB first
//   S_ADDR  | 7 device-address bits of a token
//   S_ENDP  | 4 endpoint bits of a token
//   S_FRAME | 11 frame-number bits of an SOF
//   S_CRC5  | 5 CRC5 bits of a token/SOF
//   S_DATA  | data payload + CRC16, until cs2_l drops
//   S_EOP   | single end-of-packet cycle
//   S_ERROR | bad PID or stuff error, held until cs2_l drops
module usb_bit_unstuff #(
    parameter int STUFF_LEN = 6
) (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       unstuff_din,
    input  logic       cs2_l,
    output logic       unstuff_dout,
    output logic       halt_rx_shift,
    output logic       cs2_out_l,
    output logic       idle_or_sync,
    output logic       pid,
    output logic       dev_address,
    output logic       end_point_address,
    output logic       crc5,
    output logic       frame_number,
    output logic       data_crc_eop,
    output logic       error,
    output logic       eop,
    output logic [8:0] qualify_out
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PID,
        S_ADDR,
        S_ENDP,
        S_FRAME,
        S_CRC5,
        S_DATA,
        S_EOP,
        S_ERROR
    } state_t;

    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);
    localparam logic [7:0] SYNC_PAT  = 8'b0000_0001;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  ones_q, ones_d;
    logic [6:0]  sync_q, sync_d;
    logic [6:0]  pid_q, pid_d;
    logic        dout_q, dout_d;
    logic        halt_q, halt_d;
    logic        cs2_q;
    logic [8:0]  qual_q, qual_d;

    logic        stuff_bit;
    logic        stuff_err;
    logic [7:0]  sync_shift;
    logic [7:0]  pid_full;

    // The bit sampled while the ones count sits at STUFF_LEN is the stuffed bit.
    assign stuff_bit  = (ones_q == STUFF_CNT);
    assign stuff_err  = stuff_bit & unstuff_din;
    assign sync_shift = {sync_q, unstuff_din};
    assign pid_full   = {unstuff_din, pid_q};

    always_comb begin
        ones_d = 3'd0;
        dout_d = unstuff_din;
        halt_d = stuff_bit;
        if (stuff_bit) begin
            dout_d = 1'b0;
        end
        if (cs2_l && !stuff_bit && unstuff_din) begin
            ones_d = ones_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sync_d  = sync_q;
        pid_d   = pid_q;
        if (!cs2_l) begin
            sync_d  = '0;
            state_d = (state_q == S_DATA) ? S_EOP : S_IDLE;
        end else if (stuff_err && state_q != S_IDLE) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stuff_bit) begin
                        sync_d = sync_shift[6:0];
                        if (sync_shift == SYNC_PAT) begin
                            state_d = S_PID;
                            cnt_d   = 4'd7;
                        end
                    end
                end
                S_PID: begin
                    if (!stuff_bit) begin
                        pid_d = {unstuff_din, pid_q[6:1]};
                        if (cnt_q == 4'd0) begin
                            if (pid_full[7:4] != ~pid_full[3:0]) begin
                                state_d = S_ERROR;
                            end else begin
                                case (pid_full[3:0])
                                    4'b0001, 4'b1001, 4'b1101, 4'b0100: begin
                                        state_d = S_ADDR;
                                        cnt_d   = 4'd6;
                                    end
                                    4'b0101: begin
                                        state_d = S_FRAME;
                                        cnt_d   = 4'd10;
                                    end
                                    4'b0011, 4'b1011, 4'b0111, 4'b1111: state_d = S_DATA;
                                    default: state_d = S_EOP;
                                endcase
                            end
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (!stuff_bit) begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_ENDP;
                            cnt_d   = 4'd3;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_ENDP, S_FRAME: begin
                    if (!stuff_bit) begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_CRC5;
                            cnt_d   = 4'd4;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_CRC5: begin
                    if (!stuff_bit) begin
                        if (cnt_q == 4'd0) begin
                            state_d = S_EOP;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                // EOP lasts one cycle regardless of stuffing; start the sync hunt clean.
                S_EOP: begin
                    state_d = S_IDLE;
                    sync_d  = '0;
                end
                S_DATA, S_ERROR: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        qual_d = 9'b1_0000_0000;
        case (state_q)
            S_IDLE:  qual_d = 9'b1_0000_0000;
            S_PID:   qual_d = 9'b0_1000_0000;
            S_ADDR:  qual_d = 9'b0_0100_0000;
            S_ENDP:  qual_d = 9'b0_0010_0000;
            S_CRC5:  qual_d = 9'b0_0001_0000;
            S_FRAME: qual_d = 9'b0_0000_1000;
            S_DATA:  qual_d = 9'b0_0000_0100;
            S_ERROR: qual_d = 9'b0_0000_0010;
            S_EOP:   qual_d = 9'b0_0000_0001;
            default: qual_d = 9'b1_0000_0000;
        endcase
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ones_q  <= 3'd0;
            sync_q  <= '0;
            pid_q   <= '0;
            dout_q  <= 1'b0;
            halt_q  <= 1'b0;
            cs2_q   <= 1'b1;
            qual_q  <= 9'b1_0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            sync_q  <= sync_d;
            pid_q   <= pid_d;
            dout_q  <= dout_d;
            halt_q  <= halt_d;
            cs2_q   <= cs2_l;
            qual_q  <= qual_d;
        end
    end

    assign unstuff_dout      = dout_q;
    assign halt_rx_shift     = halt_q;
    assign cs2_out_l         = cs2_q;
    assign qualify_out       = qual_q;
    assign idle_or_sync      = qual_q[8];
    assign pid               = qual_q[7];
    assign dev_address       = qual_q[6];
    assign end_point_address = qual_q[5];
    assign crc5              = qual_q[4];
    assign frame_number      = qual_q[3];
    assign data_crc_eop      = qual_q[2];
    assign error             = qual_q[1];
    assign eop               = qual_q[0];

endmodule

// File: tb/tb_usb_bit_unstuff.sv
// Directed bench for usb_bit_unstuff: stuffing/halt timing, clears, reset and field tagging.
module tb_usb_bit_unstuff;

    logic       gclk = 1'b0;
    logic       reset_l;
    logic       unstuff_din;
    logic       cs2_l;
    logic       unstuff_dout;
    logic       halt_rx_shift;
    logic       cs2_out_l;
    logic       idle_or_sync;
    logic       pid;
    logic       dev_address;
    logic       end_point_address;
    logic       crc5;
    logic       frame_number;
    logic       data_crc_eop;
    logic       error;
    logic       eop;
    logic [8:0] qualify_out;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [8:0] Q_IDLE = 9'b1_0000_0000;
    localparam logic [8:0] Q_PID  = 9'b0_1000_0000;
    localparam logic [8:0] Q_ADDR = 9'b0_0100_0000;
    localparam logic [8:0] Q_ENDP = 9'b0_0010_0000;
    localparam logic [8:0] Q_CRC5 = 9'b0_0001_0000;
    localparam logic [8:0] Q_DATA = 9'b0_0000_0100;
    localparam logic [8:0] Q_ERR  = 9'b0_0000_0010;
    localparam logic [8:0] Q_EOP  = 9'b0_0000_0001;

    usb_bit_unstuff #(.STUFF_LEN(6)) dut (
        .gclk              (gclk),
        .reset_l           (reset_l),
        .unstuff_din       (unstuff_din),
        .cs2_l             (cs2_l),
        .unstuff_dout      (unstuff_dout),
        .halt_rx_shift     (halt_rx_shift),
        .cs2_out_l         (cs2_out_l),
        .idle_or_sync      (idle_or_sync),
        .pid               (pid),
        .dev_address       (dev_address),
        .end_point_address (end_point_address),
        .crc5              (crc5),
        .frame_number      (frame_number),
        .data_crc_eop      (data_crc_eop),
        .error             (error),
        .eop               (eop),
        .qualify_out       (qualify_out)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one bit, then land 1 ns after the edge that registers it.
    task automatic drive(input logic b, input logic c);
        unstuff_din = b;
        cs2_l       = c;
        @(posedge gclk);
        #1;
    endtask

    // Send n bits in time order (bits[0] first), all expected with the same field tag.
    task automatic send(input logic [31:0] bits, input int n, input logic [8:0] expq, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(bits[i], 1'b1);
            chk(tag, qualify_out, expq);
            chk({tag, "_dout"}, {8'd0, unstuff_dout}, {8'd0, bits[i]});
            chk({tag, "_halt"}, {8'd0, halt_rx_shift}, 9'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dout"}, {8'd0, unstuff_dout}, 9'd0);
        chk({tag, "_halt"}, {8'd0, halt_rx_shift}, 9'd0);
        chk({tag, "_cs2o"}, {8'd0, cs2_out_l}, 9'd1);
        chk({tag, "_qual"}, qualify_out, Q_IDLE);
    endtask

    task automatic ones_then_stuff(input string tag);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            chk({tag, "_halt1"}, {8'd0, halt_rx_shift}, 9'd0);
            chk({tag, "_dout1"}, {8'd0, unstuff_dout}, 9'd1);
        end
        drive(1'b0, 1'b1);
        chk({tag, "_haltS"}, {8'd0, halt_rx_shift}, 9'd1);
        chk({tag, "_doutS"}, {8'd0, unstuff_dout}, 9'd0);
    endtask

    task automatic plain_bit(input logic b, input string tag);
        drive(b, 1'b1);
        chk({tag, "_halt"}, {8'd0, halt_rx_shift}, 9'd0);
        chk({tag, "_dout"}, {8'd0, unstuff_dout}, {8'd0, b});
    endtask

    initial begin
        reset_l     = 1'b0;
        unstuff_din = 1'b0;
        cs2_l       = 1'b1;
        #12;
        check_reset_vals("rst");
        #4;
        reset_l = 1'b1;

        ones_then_stuff("cnt_a");
        ones_then_stuff("cnt_b");

        for (int i = 0; i < 3; i++) plain_bit(1'b1, "rs1");
        for (int i = 0; i < 2; i++) plain_bit(1'b0, "rs0");
        for (int i = 0; i < 5; i++) plain_bit(1'b1, "rs1b");

        plain_bit(1'b1, "pre_ar");
        reset_l = 1'b0;
        #2;
        check_reset_vals("async_rst");
        #8;
        reset_l = 1'b1;
        for (int i = 0; i < 3; i++) plain_bit(1'b0, "ar0");
        for (int i = 0; i < 3; i++) plain_bit(1'b1, "ar1");
        for (int i = 0; i < 10; i++) plain_bit((i % 2) == 0, "ar_alt");

        for (int i = 0; i < 3; i++) plain_bit(1'b1, "clr_pre");
        drive(1'b1, 1'b0);
        chk("clr_cs2o_lo", {8'd0, cs2_out_l}, 9'd0);
        ones_then_stuff("clr_a");
        chk("clr_cs2o_hi", {8'd0, cs2_out_l}, 9'd1);
        ones_then_stuff("clr_b");

        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        send(32'h80, 8, Q_IDLE, "tok_sync");
        send(32'hE1, 8, Q_PID, "tok_pid");
        chk("tok_pid_port", {8'd0, pid}, 9'd1);
        send(32'h2A, 7, Q_ADDR, "tok_addr");
        chk("tok_addr_port", {8'd0, dev_address}, 9'd1);
        send(32'hC, 4, Q_ENDP, "tok_endp");
        chk("tok_endp_port", {8'd0, end_point_address}, 9'd1);
        send(32'hA, 5, Q_CRC5, "tok_crc5");
        chk("tok_crc5_port", {8'd0, crc5}, 9'd1);
        send(32'h0, 1, Q_EOP, "tok_eop");
        chk("tok_eop_port", {8'd0, eop}, 9'd1);
        send(32'h0, 1, Q_IDLE, "tok_idle");
        chk("tok_idle_port", {8'd0, idle_or_sync}, 9'd1);

        drive(1'b0, 1'b0);
        send(32'h80, 8, Q_IDLE, "bp_sync");
        send(32'h01, 8, Q_PID, "bp_pid");
        send(32'h0, 3, Q_ERR, "bp_err");
        chk("bp_err_port", {8'd0, error}, 9'd1);
        drive(1'b0, 1'b0);
        chk("bp_err_clr_cyc", qualify_out, Q_ERR);
        drive(1'b0, 1'b1);
        chk("bp_idle", qualify_out, Q_IDLE);
        chk("bp_err_port0", {8'd0, error}, 9'd0);

        send(32'h80, 8, Q_IDLE, "st_sync");
        send(32'hC3, 8, Q_PID, "st_pid");
        send(32'h0, 1, Q_DATA, "st_data0");
        chk("st_data_port", {8'd0, data_crc_eop}, 9'd1);
        send(32'h3F, 6, Q_DATA, "st_ones");
        drive(1'b1, 1'b1);
        chk("st_halt", {8'd0, halt_rx_shift}, 9'd1);
        chk("st_dout", {8'd0, unstuff_dout}, 9'd0);
        chk("st_qual", qualify_out, Q_DATA);
        drive(1'b0, 1'b1);
        chk("st_err", qualify_out, Q_ERR);
        chk("st_err_port", {8'd0, error}, 9'd1);
        drive(1'b0, 1'b1);
        chk("st_err_hold", qualify_out, Q_ERR);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        chk("st_idle", qualify_out, Q_IDLE);

        send(32'h80, 8, Q_IDLE, "de_sync");
        send(32'h4B, 8, Q_PID, "de_pid");
        send(32'h2, 2, Q_DATA, "de_data");
        drive(1'b0, 1'b0);
        chk("de_last_data", qualify_out, Q_DATA);
        chk("de_cs2o_lo", {8'd0, cs2_out_l}, 9'd0);
        drive(1'b0, 1'b1);
        chk("de_eop", qualify_out, Q_EOP);
        chk("de_eop_port", {8'd0, eop}, 9'd1);
        chk("de_cs2o_hi", {8'd0, cs2_out_l}, 9'd1);
        drive(1'b0, 1'b1);
        chk("de_idle", qualify_out, Q_IDLE);
        chk("de_eop_port0", {8'd0, eop}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_bit_unstuff.md
Name: usb_bit_unstuff

Overview:
- USB 2.0 receive-path bit unstuffer with a packet-field tracker.
- Input: serial NRZI-decoded bit stream, one bit per gclk.
- Removes stuffed zeros, flags the removed bit with halt_rx_shift, and labels every output bit with a one-hot field qualifier (sync/PID/address/endpoint/CRC5/frame/data/error/EOP).
- Sits between the NRZI decoder/EOP detector and the receive shift register/packet decoder.

Parameters:
- STUFF_LEN, 6, number of consecutive ones after which the next bit is a stuffed bit.

Ports:
- gclk  input  1  system clock, all state on rising edge.
- reset_l  input  1  asynchronous active-low reset.
- unstuff_din  input  1  NRZI-decoded serial bit, one per clock.
- cs2_l  input  1  active-low synchronous clear from the upstream EOP/SE0 detector.
- unstuff_dout  output  1  registered data bit.
- halt_rx_shift  output  1  high when unstuff_dout is a stuffed bit; the receiver must not shift it.
- cs2_out_l  output  1  cs2_l registered one cycle, forwarded downstream.
- idle_or_sync  output  1  current bit belongs to idle or sync.
- pid  output  1  current bit belongs to the PID.
- dev_address  output  1  current bit belongs to the 7-bit address.
- end_point_address  output  1  current bit belongs to the 4-bit endpoint.
- crc5  output  1  current bit belongs to CRC5.
- frame_number  output  1  current bit belongs to the 11-bit SOF frame number.
- data_crc_eop  output  1  current bit belongs to the data payload/CRC16.
- error  output  1  packet error state.
- eop  output  1  end-of-packet strobe.
- qualify_out  output  9  {idle_or_sync, pid, dev_address, end_point_address, crc5, frame_number, data_crc_eop, error, eop}.

Behaviour:
- Reset values:
  - unstuff_dout=0, halt_rx_shift=0, cs2_out_l=1.
  - Ones counter=0; FSM=IDLE; qualify_out=9'b1_0000_0000.
- Latency: every output is registered and aligned to the bit on unstuff_dout, one cycle after unstuff_din is sampled.
- Ones counter (3 bits):
  - Increments on each sampled 1; clears on a sampled 0.
  - When the count equals STUFF_LEN, the next sampled bit is the stuffed bit:
    - halt_rx_shift=1 for that bit's output cycle; unstuff_dout=0 in that cycle.
    - The counter clears regardless of the bit's value, so counting restarts from 0.
    - If the stuffed bit is 1, a stuff error is raised.
  - The counter operates in every FSM state, including IDLE.
  - A stuff error is ignored in IDLE and moves any other state to ERROR.
- FSM bit counters do not advance on halted bits.
- cs2_l low (sampled):
  - Clears the ones counter and the sync shift register.
  - DATA state -> EOP; any other state -> IDLE.
  - Takes priority over all other transitions in the same cycle.
- qualify_out is exactly one-hot at all times.
- FSM states and transitions:
  - IDLE (idle_or_sync): 8-bit shift register of the last unstuffed bits. Sync is the time-ordered sequence 0000_0001. On its final 1 (still labelled idle_or_sync) -> PID.
  - PID (8 bits, LSB first): at the 8th bit check pid[7:4] == ~pid[3:0]. On mismatch -> ERROR. Otherwise decode pid[3:0]:
    - OUT 0001, IN 1001, SETUP 1101, PING 0100 -> ADDR.
    - SOF 0101 -> FRAME.
    - DATA0 0011, DATA1 1011, DATA2 0111, MDATA 1111 -> DATA.
    - All others (handshakes, PRE, SPLIT, reserved) -> EOP.
  - ADDR: 7 bits -> ENDP.
  - ENDP: 4 bits -> CRC5.
  - FRAME: 11 bits -> CRC5.
  - CRC5: 5 bits -> EOP.
  - DATA (data_crc_eop): unbounded; leaves only on cs2_l low (-> EOP) or a stuff error (-> ERROR).
  - EOP: exactly one cycle -> IDLE.
  - ERROR: held until cs2_l low or reset -> IDLE.
- Reset mid-packet: immediate return to reset values, asynchronously; no partial field survives.

Test Plan:
- Counter from reset: din 1 x6 then 0 -> halt_rx_shift=1 for exactly the cycle the 0 reaches unstuff_dout, unstuff_dout=0, counter=0. Repeat 1 x6, 0 -> same halt pulse.
- Counter restart: after a halt, din 1 x3, 0 x2, 1 x5 -> halt_rx_shift stays 0 throughout.
- Async reset: reset_l low 10 ns mid-stream -> all outputs at reset values immediately. Then 0 x3, 1 x3, ten alternating bits -> no halt; unstuff_dout is din delayed one cycle.
- Clear: cs2_l low one cycle -> cs2_out_l low one cycle later, counter cleared. Then 1 x6, 0 -> halt pulse; 1 x6, 0 -> second halt pulse.
- Token packet: sync 0000_0001, PID OUT (bits 1,0,0,0,0,1,1,1), 7 address bits, 4 endpoint bits, 5 CRC bits -> qualify_out steps through 100000000, 010000000 (x8), 001000000 (x7), 000100000 (x4), 000010000 (x5), 000000001 (x1), then back to 100000000.
- Errors:
  - PID with bad check nibble -> error=1 until cs2_l low.
  - Seven ones inside DATA -> error=1.
  - DATA packet ended by cs2_l -> eop=1 for one cycle.
